// File: rtl/hash_digest_verifier_pkg.sv
// Shared definitions for the 16-bit four-word hash verifier.
// Holds the initial working values, the round constant table, the
// controller state encoding and the rotate / schedule-mixing helpers.
package hash16_pkg;

   localparam int MSG_BYTES = 6;
   localparam int DIGEST_W  = 64;

   localparam logic [15:0] IV_A = 16'h6A09;
   localparam logic [15:0] IV_B = 16'hBB67;
   localparam logic [15:0] IV_C = 16'h3C6E;
   localparam logic [15:0] IV_D = 16'hA54F;

   localparam logic [15:0] K_TABLE [8] = '{
      16'h428A, 16'h7137, 16'hB5C0, 16'hE9B5,
      16'h3956, 16'h59F1, 16'h923F, 16'hAB1C
   };

   typedef enum logic [2:0] {
      LOAD,
      SCHED,
      ROUND,
      COMPARE,
      DONE
   } state_t;

   // n must lie in 1..15
   function automatic logic [15:0] rotl16(input logic [15:0] x, input int unsigned n);
      return (x << n) | (x >> (16 - n));
   endfunction

   function automatic logic [15:0] rotr16(input logic [15:0] x, input int unsigned n);
      return (x >> n) | (x << (16 - n));
   endfunction

   // Schedule mixing function used to expand W4..W7.
   function automatic logic [15:0] sig16(input logic [15:0] x);
      return rotl16(x, 2) ^ rotr16(x, 7) ^ (x >> 3);
   endfunction

endpackage

// File: rtl/hash_digest_verifier_if.sv
// Bus bundle for the hash verifier.
//   s_valid/s_ready/s_data : message byte stream (byte 0 first)
//   exp_digest             : expected {a,b,c,d}, sampled with the 6th byte
//   r_valid/r_ready        : result handshake
//   r_digest/r_match       : computed digest and equality flag
//   busy                   : verifier is not idle in LOAD
// slave is the verifier side, master the message source / result sink.
interface hash_digest_verifier_if;
   import hash16_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [7:0]          s_data;
   logic [DIGEST_W-1:0] exp_digest;
   logic                r_valid;
   logic                r_ready;
   logic [DIGEST_W-1:0] r_digest;
   logic                r_match;
   logic                busy;

   modport slave (
      input  s_valid, s_data, exp_digest, r_ready,
      output s_ready, r_valid, r_digest, r_match, busy
   );

   modport master (
      output s_valid, s_data, exp_digest, r_ready,
      input  s_ready, r_valid, r_digest, r_match, busy
   );

endinterface

// File: rtl/hash_digest_verifier_round.sv
// One compression round of the 16-bit hash, purely combinational.
//   a,b,c,d            : current working registers
//   k, w               : round constant and schedule word for this round
//   a_next .. d_next   : working registers after the round
// All additions wrap modulo 2^16.
module hash16_round
   import hash16_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] k,
   input  logic [15:0] w,
   output logic [15:0] a_next,
   output logic [15:0] b_next,
   output logic [15:0] c_next,
   output logic [15:0] d_next
);

   logic [15:0] s1, ch, t1;
   logic [15:0] s0, maj, t2;

   always_comb begin
      s1  = rotl16(c, 2) + rotl16(c, 9);
      ch  = (b & c) | (~b & d);
      t1  = s1 ^ ch ^ (d & k) ^ w;
      s0  = rotl16(a, 5) + rotl16(a, 11);
      maj = (a & b) | (b & c) | (c & a);
      t2  = maj | s0;
      // b and d take the freshly computed a and c, not the old ones
      a_next = t1 + t2;
      b_next = a_next;
      c_next = a_next + t1;
      d_next = c_next;
   end

endmodule

// File: rtl/hash_digest_verifier.sv
// Receiving-end verifier for the 16-bit four-word hash.
// Collects a 6-byte message on the byte stream, expands the schedule in
// one cycle, runs ROUNDS compression rounds (one per clock) through a
// single shared round unit, then presents the digest and a match flag
// against the expected digest captured with the last byte.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of hash_digest_verifier_if (stream, result, busy)
module hash_digest_verifier
   import hash16_pkg::*;
#(
   parameter int ROUNDS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   hash_digest_verifier_if.slave  bus
);

   state_t              state;
   logic [2:0]          byte_cnt;
   logic [2:0]          nz_cnt;
   logic [2:0]          rnd;
   logic [7:0]          msg [MSG_BYTES];
   logic [15:0]         sched_w [8];
   logic [15:0]         w_next [8];
   logic [15:0]         a, b, c, d;
   logic [15:0]         a_nx, b_nx, c_nx, d_nx;
   logic [DIGEST_W-1:0] exp_q;
   logic [DIGEST_W-1:0] r_digest;
   logic                r_match;
   logic                r_valid;
   logic                s_ready;
   logic                busy;
   logic                s_fire;

   assign s_fire       = bus.s_valid & s_ready;
   assign bus.s_ready  = s_ready;
   assign bus.r_valid  = r_valid;
   assign bus.r_digest = r_digest;
   assign bus.r_match  = r_match;
   assign bus.busy     = busy;

   // Schedule expansion from the collected bytes and the nonzero count.
   always_comb begin
      w_next[0] = {msg[0], msg[1]};
      w_next[1] = {msg[2], msg[3]};
      w_next[2] = {msg[4], msg[5]};
      w_next[3] = {13'b0, nz_cnt};
      w_next[4] = sig16(w_next[1]) + w_next[3];
      w_next[5] = sig16(w_next[2]) + w_next[4];
      w_next[6] = sig16(w_next[3]) + w_next[5];
      w_next[7] = sig16(w_next[4]) + w_next[6];
   end

   hash16_round u_round (
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .k      (K_TABLE[rnd]),
      .w      (sched_w[rnd]),
      .a_next (a_nx),
      .b_next (b_nx),
      .c_next (c_nx),
      .d_next (d_nx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LOAD;
         byte_cnt <= 3'd0;
         nz_cnt   <= 3'd0;
         rnd      <= 3'd0;
         for (int i = 0; i < MSG_BYTES; i++) msg[i] <= 8'd0;
         for (int i = 0; i < 8; i++) sched_w[i] <= 16'd0;
         a        <= 16'd0;
         b        <= 16'd0;
         c        <= 16'd0;
         d        <= 16'd0;
         exp_q    <= '0;
         r_digest <= '0;
         r_match  <= 1'b0;
         r_valid  <= 1'b0;
         s_ready  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (s_fire) begin
                  msg[byte_cnt] <= bus.s_data;
                  byte_cnt      <= byte_cnt + 3'd1;
                  if (bus.s_data != 8'd0) nz_cnt <= nz_cnt + 3'd1;
                  // The expected digest is only meaningful alongside the last byte.
                  if (byte_cnt == 3'(MSG_BYTES - 1)) begin
                     exp_q   <= bus.exp_digest;
                     s_ready <= 1'b0;
                     busy    <= 1'b1;
                     state   <= SCHED;
                  end
               end
            end
            SCHED: begin
               for (int i = 0; i < 8; i++) sched_w[i] <= w_next[i];
               a     <= IV_A;
               b     <= IV_B;
               c     <= IV_C;
               d     <= IV_D;
               rnd   <= 3'd0;
               state <= ROUND;
            end
            ROUND: begin
               a <= a_nx;
               b <= b_nx;
               c <= c_nx;
               d <= d_nx;
               if (rnd == 3'(ROUNDS - 1)) state <= COMPARE;
               else                       rnd   <= rnd + 3'd1;
            end
            COMPARE: begin
               r_digest <= {a, b, c, d};
               r_match  <= ({a, b, c, d} == exp_q);
               r_valid  <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (bus.r_ready) begin
                  r_valid  <= 1'b0;
                  byte_cnt <= 3'd0;
                  nz_cnt   <= 3'd0;
                  rnd      <= 3'd0;
                  s_ready  <= 1'b1;
                  busy     <= 1'b0;
                  state    <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_digest_verifier.sv
// Self-checking bench for hash_digest_verifier (default 8-round build plus
// a 1-round build). A behavioural digest model predicts every result; a
// monitor compares the result port on every cycle it is valid.
module tb_hash_digest_verifier;
   import hash16_pkg::*;

   localparam int P = 10;

   localparam logic [15:0] KT [8] = '{
      16'h428A, 16'h7137, 16'hB5C0, 16'hE9B5,
      16'h3956, 16'h59F1, 16'h923F, 16'hAB1C
   };

   typedef struct {
      logic [63:0] dig;
      logic        match;
      time         t;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #(P/2) clk = ~clk;

   hash_digest_verifier_if bus ();
   hash_digest_verifier_if bus1 ();

   hash_digest_verifier #(.ROUNDS(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   hash_digest_verifier #(.ROUNDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int errors = 0;
   int checks = 0;
   int results = 0;
   exp_t q[$];

   logic [15:0] mw [8];
   logic [2:0]  mcount;

   logic [7:0] m01  [6] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] mx   [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
   logic [7:0] mcnt [6] = '{8'hFF, 8'h00, 8'h7A, 8'h00, 8'h00, 8'h01};
   logic [7:0] mg   [6] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h42};
   logic [7:0] mb   [6] = '{8'h80, 8'h01, 8'h02, 8'h40, 8'hC3, 8'h3C};
   logic [7:0] mz   [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [15:0] mrot(input logic [15:0] x, input int n);
      logic [31:0] dbl;
      int s;
      s   = ((n % 16) + 16) % 16;
      dbl = {x, x} << s;
      return dbl[31:16];
   endfunction

   function automatic logic [15:0] msig(input logic [15:0] x);
      return mrot(x, 2) ^ mrot(x, -7) ^ (x >> 3);
   endfunction

   function automatic void model_sched(input logic [7:0] m [6]);
      int nz;
      nz = 0;
      for (int i = 0; i < 6; i++) if (m[i] != 8'd0) nz++;
      mcount = 3'(nz);
      for (int i = 0; i < 3; i++) mw[i] = {m[2*i], m[2*i+1]};
      mw[3] = {13'b0, mcount};
      for (int i = 4; i < 8; i++) mw[i] = msig(mw[i-3]) + mw[i-1];
   endfunction

   function automatic logic [63:0] model_digest(input logic [7:0] m [6], input int rounds);
      logic [15:0] a, b, c, d, t1, t2;
      model_sched(m);
      a = 16'h6A09; b = 16'hBB67; c = 16'h3C6E; d = 16'hA54F;
      for (int i = 0; i < rounds; i++) begin
         t1 = (mrot(c, 2) + mrot(c, 9)) ^ ((b & c) | (~b & d)) ^ (d & KT[i]) ^ mw[i];
         t2 = ((a & b) | (b & c) | (c & a)) | (mrot(a, 5) + mrot(a, 11));
         a = t1 + t2;
         b = a;
         c = a + t1;
         d = c;
      end
      return {a, b, c, d};
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_msg(input logic [7:0] m [6], input logic [63:0] expd,
                           input bit gaps, input bit chk_sched);
      exp_t e;
      int n;
      e.dig   = model_digest(m, 8);
      e.match = (e.dig == expd);
      e.t     = 0;
      for (int i = 0; i < 6; i++) begin
         if (gaps) begin
            for (int g = 0; g < i % 4; g++) begin
               bus.s_valid = 1'b0;
               tick();
               chk("byte_cnt_hold", 64'(dut.byte_cnt), 64'(i));
            end
         end
         bus.s_valid = 1'b1;
         bus.s_data  = m[i];
         if (i == 5) bus.exp_digest = expd;
         n = 0;
         while (!bus.s_ready) begin
            tick();
            n++;
            if (n > 300) begin
               $display("FAIL s_ready_timeout: got s_ready=0 expected 1 within 300 cycles");
               $fatal(1, "stream stuck");
            end
         end
         tick();
         if (i == 5) begin
            e.t = $time - 1;
            q.push_back(e);
         end
      end
      bus.s_valid    = 1'b0;
      bus.exp_digest = ~expd;
      tick();
      if (chk_sched) begin
         model_sched(m);
         for (int k = 0; k < 8; k++)
            chk($sformatf("sched_w%0d", k), 64'(dut.sched_w[k]), 64'(mw[k]));
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.r_valid || !bus.s_ready) begin
         tick();
         n++;
         if (n > 300) begin
            $display("FAIL idle_timeout: got r_valid=%0b s_ready=%0b expected idle", bus.r_valid, bus.s_ready);
            $fatal(1, "result stuck");
         end
      end
   endtask

   // ---------------- result monitor ----------------
   exp_t cur;
   bit   active = 1'b0;
   bit   hs = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         active = 1'b0;
         hs     = 1'b0;
      end else if (bus.r_valid) begin
         if (!active) begin
            active = 1'b1;
            chk("pending_result", 64'(q.size()), 64'd1);
            if (q.size() > 0) cur = q.pop_front();
            chk("r_digest", bus.r_digest, cur.dig);
            chk("r_match", 64'(bus.r_match), 64'(cur.match));
            chk("latency", 64'($time - cur.t), 64'(10*P + P/2));
            results++;
         end else begin
            chk("hold_digest", bus.r_digest, cur.dig);
            chk("hold_match", 64'(bus.r_match), 64'(cur.match));
         end
         chk("s_ready_in_done", 64'(bus.s_ready), 64'd0);
         chk("busy_in_done", 64'(bus.busy), 64'd1);
         hs = bus.r_ready;
      end else if (active) begin
         chk("handshake_before_drop", 64'(hs), 64'd1);
         chk("s_ready_after_hs", 64'(bus.s_ready), 64'd1);
         chk("busy_after_hs", 64'(bus.busy), 64'd0);
         active = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] d;
      int r0, n;
      time t1acc;

      bus.s_valid = 0;  bus.s_data = 0;  bus.exp_digest = 0;  bus.r_ready = 1;
      bus1.s_valid = 0; bus1.s_data = 0; bus1.exp_digest = 0; bus1.r_ready = 1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
      chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
      chk("rst_r_match", 64'(bus.r_match), 64'd0);
      chk("rst_r_digest", bus.r_digest, 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      rst = 1'b0;
      tick();

      // Hand-computed values that pin the model.
      model_sched(m01);
      chk("model_m0", 64'(mw[0]), 64'h0100);
      chk("model_m3", 64'(mw[3]), 64'h0001);
      chk("model_w4", 64'(mw[4]), 64'h0001);
      chk("model_w5", 64'(mw[5]), 64'h0001);
      chk("model_w6", 64'(mw[6]), 64'h0205);
      chk("model_w7", 64'(mw[7]), 64'h0409);
      model_sched(mcnt);
      chk("model_count", 64'(mw[3]), 64'h0003);
      model_sched(mz);
      chk("model_zero_w", 64'(mw[4] | mw[5] | mw[6] | mw[7] | mw[3]), 64'h0);
      chk("model_zero_1round", model_digest(mz, 1), 64'hB0D3B0D3A327A327);

      // Schedule message.
      send_msg(m01, model_digest(m01, 8), 1'b0, 1'b1);
      wait_idle();

      // Match then mismatch on the same message.
      d = model_digest(mx, 8);
      send_msg(mx, d, 1'b0, 1'b0);
      wait_idle();
      send_msg(mx, d ^ 64'd1, 1'b0, 1'b0);
      wait_idle();

      // Nonzero counting.
      send_msg(mcnt, model_digest(mcnt, 8), 1'b0, 1'b1);
      wait_idle();

      // Idle gaps of 0..3 cycles between bytes.
      send_msg(mg, 64'h0123456789ABCDEF, 1'b1, 1'b0);
      wait_idle();

      // All-zero message.
      send_msg(mz, model_digest(mz, 8), 1'b0, 1'b1);
      wait_idle();

      // Result backpressure with stray stream traffic.
      bus.r_ready = 1'b0;
      send_msg(mb, model_digest(mb, 8), 1'b0, 1'b0);
      n = 0;
      while (!bus.r_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_r_valid_seen", 64'(bus.r_valid), 64'd1);
      for (int i = 0; i < 20; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'hAA;
         tick();
      end
      bus.s_valid = 1'b0;
      bus.r_ready = 1'b1;
      tick();
      chk("bp_s_ready_release", 64'(bus.s_ready), 64'd1);
      chk("bp_no_consume", 64'(dut.byte_cnt), 64'd0);
      wait_idle();

      // Back-to-back messages.
      r0 = results;
      send_msg(mx, model_digest(mx, 8), 1'b0, 1'b0);
      send_msg(mg, model_digest(mg, 8), 1'b0, 1'b0);
      send_msg(mcnt, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0);
      wait_idle();
      tick();
      chk("b2b_result_count", 64'(results - r0), 64'd3);

      // Reset in the middle of the rounds.
      send_msg(mb, model_digest(mb, 8), 1'b0, 1'b0);
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst_s_ready", 64'(bus.s_ready), 64'd1);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_r_valid", 64'(bus.r_valid), 64'd0);
      chk("midrst_r_digest", bus.r_digest, 64'd0);
      q.delete();
      r0 = results;
      tick();
      rst = 1'b0;
      repeat (15) tick();
      chk("midrst_no_result", 64'(results - r0), 64'd0);
      send_msg(m01, model_digest(m01, 8) ^ 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      wait_idle();
      tick();
      chk("post_rst_result", 64'(results - r0), 64'd1);

      // One-round build on the all-zero message.
      for (int i = 0; i < 6; i++) begin
         chk("r1_s_ready", 64'(bus1.s_ready), 64'd1);
         bus1.s_valid = 1'b1;
         bus1.s_data  = 8'h00;
         if (i == 5) bus1.exp_digest = 64'hB0D3B0D3A327A327;
         tick();
      end
      t1acc = $time - 1;
      bus1.s_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus1.r_valid && n < 20);
      chk("r1_latency", 64'($time - t1acc), 64'(3*P + P/2));
      chk("r1_digest", bus1.r_digest, 64'hB0D3B0D3A327A327);
      chk("r1_match", 64'(bus1.r_match), 64'd1);
      tick();
      tick();
      chk("r1_back_to_load", 64'(bus1.s_ready), 64'd1);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
